// File: rtl/pck_control.sv
// rtl/pck_control.sv - shared ALU opcode, flag and pipeline-state types
package pck_control;

    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_sub  = 4'd1,
        alu_and  = 4'd2,
        alu_or   = 4'd3,
        alu_xor  = 4'd4,
        alu_slt  = 4'd5,
        alu_sltu = 4'd6,
        alu_sll  = 4'd7,
        alu_srl  = 4'd8,
        alu_sra  = 4'd9,
        alu_cpa  = 4'd10,
        alu_cpb  = 4'd11,
        alu_mul  = 4'd12,
        alu_mulh = 4'd13
    } sel_alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } alu_pipe_state_e;

    function automatic logic is_mul_op(input sel_alu_op_e op);
        return (op == alu_mul) || (op == alu_mulh);
    endfunction

endpackage

// File: rtl/alu_pipe_mul_iter.sv
// rtl/alu_pipe_mul_iter.sv - iterative shift-add unsigned multiplier, one partial product per cycle
module alu_mul_iter #(
    parameter int BITS = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              start_i,
    input  logic [BITS-1:0]   a_i,
    input  logic [BITS-1:0]   b_i,
    output logic              done_o,
    output logic [2*BITS-1:0] prod_o
);

    localparam int CNT_W = $clog2(BITS + 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [2*BITS-1:0] acc_q, acc_d;
    logic [2*BITS-1:0] mcand_q;
    logic [BITS-1:0]   mplier_q;
    logic              step;

    assign step  = (cnt_q != '0);
    assign acc_d = (step && mplier_q[0]) ? acc_q + mcand_q : acc_q;

    // prod_o already includes the final partial product on the done cycle,
    // so the caller can retire the result at the same edge the counter hits 0.
    assign done_o = (cnt_q == CNT_W'(1));
    assign prod_o = acc_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            cnt_q    <= CNT_W'(BITS);
            acc_q    <= '0;
            mcand_q  <= {{BITS{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (step) begin
            cnt_q    <= cnt_q - CNT_W'(1);
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered flags and tag; multiplier under ALU_PIPE_MUL_EN
module alu_pipe
    import pck_control::*;
#(
    parameter int BITS  = 8,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  sel_alu_op_e      i_sel_op,
    input  logic [BITS-1:0]  i_op_a,
    input  logic [BITS-1:0]  i_op_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [BITS-1:0]  o_res,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_ovf
);

    localparam int SHW = $clog2(BITS);

    logic             valid_q;
    logic [BITS-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_q;
    alu_flags_t       flags_q, flags_d;
    logic [BITS:0]    sum, diff;
    logic [SHW-1:0]   shamt;
    logic             out_free;
    logic             accept;

    assign sum   = {1'b0, i_op_a} + {1'b0, i_op_b};
    assign diff  = {1'b0, i_op_a} - {1'b0, i_op_b};
    assign shamt = i_op_b[SHW-1:0];

    always_comb begin
        res_d         = '0;
        flags_d       = '0;
        case (i_sel_op)
            alu_add: begin
                res_d         = sum[BITS-1:0];
                flags_d.carry = sum[BITS];
                flags_d.ovf   = (i_op_a[BITS-1] == i_op_b[BITS-1]) && (sum[BITS-1] != i_op_a[BITS-1]);
            end
            alu_sub: begin
                res_d         = diff[BITS-1:0];
                flags_d.carry = diff[BITS];
                flags_d.ovf   = (i_op_a[BITS-1] != i_op_b[BITS-1]) && (diff[BITS-1] != i_op_a[BITS-1]);
            end
            alu_and:  res_d = i_op_a & i_op_b;
            alu_or:   res_d = i_op_a | i_op_b;
            alu_xor:  res_d = i_op_a ^ i_op_b;
            alu_slt:  res_d = {{(BITS-1){1'b0}}, $signed(i_op_a) < $signed(i_op_b)};
            alu_sltu: res_d = {{(BITS-1){1'b0}}, i_op_a < i_op_b};
            alu_sll:  res_d = i_op_a << shamt;
            alu_srl:  res_d = i_op_a >> shamt;
            alu_sra:  res_d = $unsigned($signed(i_op_a) >>> shamt);
            alu_cpa:  res_d = i_op_a;
            alu_cpb:  res_d = i_op_b;
            default:  res_d = '0;
        endcase
        flags_d.zero = (res_d == '0);
    end

    assign out_free = !valid_q || i_ready;

`ifdef ALU_PIPE_MUL_EN
    alu_pipe_state_e   state_q;
    logic              mulh_q;
    logic [TAG_W-1:0]  mtag_q;
    logic              mul_start;
    logic              mul_done;
    logic [2*BITS-1:0] mul_prod;
    logic [BITS-1:0]   mul_res;

    assign o_ready   = (state_q == S_IDLE) && out_free;
    assign accept    = i_valid && o_ready;
    assign mul_start = accept && is_mul_op(i_sel_op);
    assign mul_res   = mulh_q ? mul_prod[2*BITS-1:BITS] : mul_prod[BITS-1:0];

    alu_mul_iter #(.BITS(BITS)) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .start_i (mul_start),
        .a_i     (i_op_a),
        .b_i     (i_op_b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`else
    assign o_ready = out_free;
    assign accept  = i_valid && o_ready;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            tag_q   <= '0;
            flags_q <= '0;
`ifdef ALU_PIPE_MUL_EN
            state_q <= S_IDLE;
            mulh_q  <= 1'b0;
            mtag_q  <= '0;
`endif
        end else begin
            if (valid_q && i_ready) valid_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            case (state_q)
                S_IDLE: begin
                    if (mul_start) begin
                        mulh_q  <= (i_sel_op == alu_mulh);
                        mtag_q  <= i_tag;
                        state_q <= S_MUL;
                    end else if (accept) begin
                        valid_q <= 1'b1;
                        res_q   <= res_d;
                        tag_q   <= i_tag;
                        flags_q <= flags_d;
                    end
                end
                S_MUL, S_HOLD: begin
                    // In S_HOLD the counter is 0, so mul_prod is the held accumulator.
                    if ((state_q == S_HOLD || mul_done) && out_free) begin
                        valid_q <= 1'b1;
                        res_q   <= mul_res;
                        tag_q   <= mtag_q;
                        flags_q <= '{zero: (mul_res == '0), carry: 1'b0, ovf: 1'b0};
                        state_q <= S_IDLE;
                    end else if (mul_done) begin
                        state_q <= S_HOLD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
`else
            if (accept) begin
                valid_q <= 1'b1;
                res_q   <= res_d;
                tag_q   <= i_tag;
                flags_q <= flags_d;
            end
`endif
        end
    end

    assign o_valid = valid_q;
    assign o_res   = res_q;
    assign o_tag   = tag_q;
    assign o_zero  = flags_q.zero;
    assign o_carry = flags_q.carry;
    assign o_ovf   = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (BITS=8, TAG_W=4)
module tb_alu_pipe;
    import pck_control::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    sel_alu_op_e i_sel_op = alu_add;
    logic [7:0]  i_op_a = '0;
    logic [7:0]  i_op_b = '0;
    logic [3:0]  i_tag = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [7:0]  o_res;
    logic [3:0]  o_tag;
    logic        o_zero, o_carry, o_ovf;

    int n_vec = 0;
    int n_err = 0;

    alu_pipe #(.BITS(8), .TAG_W(4)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sel_op (i_sel_op),
        .i_op_a   (i_op_a),
        .i_op_b   (i_op_b),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_res    (o_res),
        .o_tag    (o_tag),
        .o_zero   (o_zero),
        .o_carry  (o_carry),
        .o_ovf    (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic issue(input sel_alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] tag);
        i_valid  = 1'b1;
        i_sel_op = op;
        i_op_a   = a;
        i_op_b   = b;
        i_tag    = tag;
        step();
        i_valid  = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        n_vec++;
        if ({o_valid, o_res, o_tag, o_zero, o_carry, o_ovf} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b res=%h tag=%h z=%b c=%b o=%b expected all 0",
                     o_valid, o_res, o_tag, o_zero, o_carry, o_ovf);
        end
        n_vec++;
        if (o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 1", o_ready);
        end
    endtask

    task automatic test_add();
        i_ready = 1'b1;
        issue(alu_add, 8'hF0, 8'h20, 4'd3);
        n_vec++;
        if ({o_valid, o_res, o_carry, o_ovf, o_zero, o_tag} !== {1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 4'd3}) begin
            n_err++;
            $display("FAIL add_f0_20: got v=%b res=%h c=%b o=%b z=%b tag=%h expected v=1 res=10 c=1 o=0 z=0 tag=3",
                     o_valid, o_res, o_carry, o_ovf, o_zero, o_tag);
        end
        issue(alu_add, 8'h7F, 8'h01, 4'd4);
        n_vec++;
        if ({o_res, o_carry, o_ovf, o_zero} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL add_7f_01: got res=%h c=%b o=%b z=%b expected res=80 c=0 o=1 z=0",
                     o_res, o_carry, o_ovf, o_zero);
        end
    endtask

    task automatic test_sub();
        issue(alu_sub, 8'h80, 8'h01, 4'd5);
        n_vec++;
        if ({o_res, o_ovf, o_carry} !== {8'h7F, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL sub_80_01: got res=%h o=%b c=%b expected res=7f o=1 c=0", o_res, o_ovf, o_carry);
        end
        issue(alu_sub, 8'h05, 8'h05, 4'd6);
        n_vec++;
        if ({o_res, o_zero, o_carry} !== {8'h00, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL sub_05_05: got res=%h z=%b c=%b expected res=00 z=1 c=0", o_res, o_zero, o_carry);
        end
        issue(alu_sub, 8'h01, 8'h02, 4'd7);
        n_vec++;
        if ({o_res, o_carry, o_ovf} !== {8'hFF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL sub_borrow: got res=%h c=%b o=%b expected res=ff c=1 o=0", o_res, o_carry, o_ovf);
        end
    endtask

    task automatic test_logic_shift();
        issue(alu_sll, 8'h01, 8'h09, 4'd1);
        n_vec++;
        if (o_res !== 8'h02) begin
            n_err++;
            $display("FAIL sll_amount_mask: got %h expected 02", o_res);
        end
        issue(alu_sra, 8'h80, 8'h03, 4'd2);
        n_vec++;
        if (o_res !== 8'hF0) begin
            n_err++;
            $display("FAIL sra_80_3: got %h expected f0", o_res);
        end
        issue(alu_srl, 8'h80, 8'h03, 4'd2);
        n_vec++;
        if (o_res !== 8'h10) begin
            n_err++;
            $display("FAIL srl_80_3: got %h expected 10", o_res);
        end
        issue(alu_slt, 8'hFF, 8'h01, 4'd3);
        n_vec++;
        if (o_res !== 8'h01) begin
            n_err++;
            $display("FAIL slt_m1_1: got %h expected 01", o_res);
        end
        issue(alu_sltu, 8'hFF, 8'h01, 4'd3);
        n_vec++;
        if ({o_res, o_zero} !== {8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL sltu_ff_1: got res=%h z=%b expected res=00 z=1", o_res, o_zero);
        end
        issue(alu_xor, 8'hA5, 8'h0F, 4'd8);
        n_vec++;
        if (o_res !== 8'hAA) begin
            n_err++;
            $display("FAIL xor_a5_0f: got %h expected aa", o_res);
        end
        issue(alu_cpb, 8'h11, 8'h3C, 4'd9);
        n_vec++;
        if (o_res !== 8'h3C) begin
            n_err++;
            $display("FAIL cpb: got %h expected 3c", o_res);
        end
        issue(sel_alu_op_e'(4'd15), 8'h05, 8'h05, 4'hA);
        n_vec++;
        if ({o_valid, o_res, o_zero, o_carry, o_ovf, o_tag} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'hA}) begin
            n_err++;
            $display("FAIL undef_op: got v=%b res=%h z=%b c=%b o=%b tag=%h expected v=1 res=00 z=1 c=0 o=0 tag=a",
                     o_valid, o_res, o_zero, o_carry, o_ovf, o_tag);
        end
    endtask

    task automatic test_mul();
        i_ready = 1'b1;
        step();
`ifdef ALU_PIPE_MUL_EN
        issue(alu_mul, 8'hFF, 8'hFF, 4'd5);
        for (int k = 1; k <= 8; k++) begin
            n_vec++;
            if ({o_ready, o_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL mul_busy_c%0d: got ready=%b valid=%b expected 0 0", k, o_ready, o_valid);
            end
            step();
        end
        n_vec++;
        if ({o_valid, o_res, o_tag, o_carry, o_ovf, o_zero, o_ready} !== {1'b1, 8'h01, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL mul_ff_ff: got v=%b res=%h tag=%h c=%b o=%b z=%b rdy=%b expected v=1 res=01 tag=5 c=0 o=0 z=0 rdy=1",
                     o_valid, o_res, o_tag, o_carry, o_ovf, o_zero, o_ready);
        end
        issue(alu_mulh, 8'hFF, 8'hFF, 4'd6);
        repeat (8) step();
        n_vec++;
        if ({o_valid, o_res, o_tag} !== {1'b1, 8'hFE, 4'd6}) begin
            n_err++;
            $display("FAIL mulhu_ff_ff: got v=%b res=%h tag=%h expected v=1 res=fe tag=6", o_valid, o_res, o_tag);
        end
        issue(alu_mulh, 8'h0F, 8'h11, 4'd7);
        repeat (8) step();
        n_vec++;
        if ({o_valid, o_res, o_zero} !== {1'b1, 8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL mulhu_0f_11: got v=%b res=%h z=%b expected v=1 res=00 z=1", o_valid, o_res, o_zero);
        end
`else
        issue(alu_mul, 8'hFF, 8'hFF, 4'd5);
        n_vec++;
        if ({o_valid, o_res, o_zero, o_tag} !== {1'b1, 8'h00, 1'b1, 4'd5}) begin
            n_err++;
            $display("FAIL mul_disabled: got v=%b res=%h z=%b tag=%h expected v=1 res=00 z=1 tag=5",
                     o_valid, o_res, o_zero, o_tag);
        end
        issue(alu_mulh, 8'hFF, 8'hFF, 4'd6);
        n_vec++;
        if ({o_valid, o_res, o_zero, o_tag} !== {1'b1, 8'h00, 1'b1, 4'd6}) begin
            n_err++;
            $display("FAIL mulhu_disabled: got v=%b res=%h z=%b tag=%h expected v=1 res=00 z=1 tag=6",
                     o_valid, o_res, o_zero, o_tag);
        end
`endif
    endtask

    task automatic test_backpressure();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        issue(alu_add, 8'h01, 8'h01, 4'd1);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({o_valid, o_res, o_zero, o_carry, o_ovf, o_tag, o_ready} !== {1'b1, 8'h02, 3'b000, 4'd1, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold_c%0d: got v=%b res=%h z=%b c=%b o=%b tag=%h rdy=%b expected v=1 res=02 flags=0 tag=1 rdy=0",
                         k, o_valid, o_res, o_zero, o_carry, o_ovf, o_tag, o_ready);
            end
            step();
        end
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_sel_op = alu_add;
        i_op_a   = 8'h03;
        i_op_b   = 8'h04;
        i_tag    = 4'd2;
        #1;
        n_vec++;
        if (o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_refill_ready: got %b expected 1", o_ready);
        end
        step();
        i_valid = 1'b0;
        n_vec++;
        if ({o_valid, o_res, o_tag} !== {1'b1, 8'h07, 4'd2}) begin
            n_err++;
            $display("FAIL bp_refill: got v=%b res=%h tag=%h expected v=1 res=07 tag=2", o_valid, o_res, o_tag);
        end
        step();
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: got v=%b expected 0", o_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        i_ready = 1'b1;
        step();
`ifdef ALU_PIPE_MUL_EN
        issue(alu_mul, 8'hFF, 8'hFF, 4'd9);
        repeat (3) step();
`else
        i_ready = 1'b0;
        issue(alu_add, 8'h10, 8'h20, 4'd9);
        i_ready = 1'b1;
`endif
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        n_vec++;
        if ({o_valid, o_ready, o_res} !== {1'b0, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL rst_mid_op: got v=%b rdy=%b res=%h expected v=0 rdy=1 res=00", o_valid, o_ready, o_res);
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (o_valid) seen = 1'b1;
            step();
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_stale: got stale o_valid=%b expected 0", seen);
        end
        issue(alu_or, 8'h50, 8'h0A, 4'd3);
        n_vec++;
        if ({o_valid, o_res, o_tag} !== {1'b1, 8'h5A, 4'd3}) begin
            n_err++;
            $display("FAIL rst_recover: got v=%b res=%h tag=%h expected v=1 res=5a tag=3", o_valid, o_res, o_tag);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Handshaked, parametrised ALU for the datapath.
- Adds valid/ready flow control on input and output, a registered status-flag output and a pass-through tag.
- Adds an optional iterative shift-add multiplier (low and unsigned-high products).
- Sits between the operand-fetch stage and writeback; single-cycle ops retire at one op per cycle, multiply ops stall the input side.

Parameters:
- BITS, 8: operand/result width, >= 2.
- TAG_W, 4: width of the opaque tag carried with each op, >= 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  input op valid
- o_ready  out  1  block can accept an op this cycle
- i_sel_op  in  sel_alu_op_e  operation select
- i_op_a  in  BITS  operand A
- i_op_b  in  BITS  operand B
- i_tag  in  TAG_W  caller tag
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_res  out  BITS  result
- o_tag  out  TAG_W  tag of the result
- o_zero  out  1  o_res == 0
- o_carry  out  1  add: carry-out; sub: borrow (a < b unsigned); other ops: 0
- o_ovf  out  1  signed overflow for add/sub; other ops: 0

Behaviour:
- Reset (i_clk edge with i_rst=1): o_valid=0, o_res=0, o_tag=0, all flags 0, FSM to S_IDLE, multiplier counter 0. Reset overrides everything, including an in-flight multiply, which is discarded.
- Transfers:
  - Input accepted when i_valid && o_ready at a clock edge.
  - Output consumed when o_valid && i_ready.
- Output register holds o_res/o_tag/flags/o_valid. These stay stable while o_valid && !i_ready.
- o_ready = (state == S_IDLE) && (!o_valid || i_ready), so same-cycle consume-and-refill sustains full throughput.
- Single-cycle ops (add, sub, and, or, xor, slt, sltu, sll, srl, sra, cpa, cpb):
  - Accepted at the end of cycle t; o_valid=1 in cycle t+1.
  - slt/sltu produce 1 or 0, zero-extended.
- Shifts (sll, srl, sra): amount = i_op_b[$clog2(BITS)-1:0]; upper bits of i_op_b are ignored. sra is arithmetic.
- Arithmetic wraps modulo 2^BITS; flags are computed on the BITS+1-bit sum/difference.
- Undefined opcode: result 0, flags per result (o_zero=1), handshake as a single-cycle op.
- FSM:
  - S_IDLE: accepting. A mul/mulhu acceptance latches the operands, op and tag, clears the BITS*2 accumulator, loads counter=BITS, and goes to S_MUL.
  - S_MUL: each cycle, add the shifted multiplicand if the current multiplier LSB is 1, then decrement the counter. When the counter reaches 0:
    - output register free (!o_valid || i_ready): write the result and go to S_IDLE.
    - otherwise: go to S_HOLD.
  - S_HOLD: wait for the output register to free, write the result, go to S_IDLE.
- Multiply latency with no backpressure: accept at end of cycle t, o_valid in cycle t+BITS+1.
  - mul returns product[BITS-1:0]; mulhu returns product[2*BITS-1:BITS] (unsigned).
  - o_carry=0, o_ovf=0, o_zero from the returned half.
- o_ready=0 throughout S_MUL and S_HOLD. i_valid is ignored there; the source must hold its op.
- Back-to-back mul: the next op can be accepted in the first S_IDLE cycle.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: multiplier, S_MUL and S_HOLD are present, as described above.
- Undefined:
  - No multiplier logic; the FSM reduces to S_IDLE only.
  - mul/mulhu complete as single-cycle ops with result 0 and o_zero=1.
  - o_ready = !o_valid || i_ready.

Decomposition:
- pck_control:
  - extend sel_alu_op_e with alu_mul and alu_mulh, appended after the existing encodings, which keep their values;
  - add typedef alu_flags_t (packed struct zero, carry, ovf);
  - add alu_pipe_state_e (S_IDLE, S_MUL, S_HOLD).
- Sub-module alu_mul_iter (BITS parameter) holds the counter, accumulator and start/done pulses. It is instantiated only under ALU_PIPE_MUL_EN.

Test Plan (BITS=8):
- add a=0xF0 b=0x20 tag=3, i_ready=1 -> next cycle o_valid=1, o_res=0x10, o_carry=1, o_ovf=0, o_zero=0, o_tag=3.
- sub a=0x80 b=0x01 -> o_res=0x7F, o_ovf=1, o_carry=0. Then sub a=0x05 b=0x05 -> o_res=0x00, o_zero=1, o_carry=0.
- sll a=0x01 b=0x09 -> o_res=0x02 (amount 1). sra a=0x80 b=0x03 -> o_res=0xF0.
- Multiply, macro defined:
  - mul a=0xFF b=0xFF -> o_ready=0 for 8 cycles; o_valid in cycle t+9, o_res=0x01.
  - mulhu same operands -> o_res=0xFE.
  - mulhu a=0x0F b=0x11 -> o_res=0x00, o_zero=1.
- Backpressure: add 0x01+0x01, hold i_ready=0 for 3 cycles -> o_res=0x02 and flags stable, o_ready=0. Raise i_ready with a new add 0x03+0x04 offered -> consume and accept in the same cycle; next cycle o_res=0x07.
- Reset mid-mul: assert i_rst during cycle 4 of S_MUL -> next cycle o_valid=0, o_ready=1, no stale result ever appears. Rerun with the macro undefined -> mul returns 0 in 1 cycle.
